// File: rtl/v_preclr_pulse_gen.sv
// v_preclr_pulse_gen: debounced set/clear buttons to exclusive pre/clr pulses plus registered d
module v_preclr_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 5,
  parameter int PULSE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_clr,
  input  logic d_in,
  output logic pre,
  output logic clr,
  output logic d,
  output logic conflict
);
  typedef enum logic [1:0] {IDLE, PRESS, PULSE, HOLD} st_t;
  typedef struct packed {
    st_t st;
    logic [CNT_W-1:0] cnt;
  } ch_t;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PL_MAX = CNT_W'(PULSE_CYCLES - 1);
  logic [1:0] sync1, sync2;
  ch_t cs, cc, ns, nc, nc_raw;
  logic cfl;
  function automatic ch_t step(input ch_t c, input logic s);
    ch_t n;
    n = c;
    case (c.st)
      IDLE: begin
        n.st = s ? PRESS : IDLE;
        n.cnt = s ? CNT_W'(1) : '0;
      end
      PRESS: begin
        n.st = !s ? IDLE : (c.cnt == DB_MAX ? PULSE : PRESS);
        n.cnt = (!s || c.cnt == DB_MAX) ? '0 : c.cnt + 1'b1;
      end
      PULSE: begin
        n.st = c.cnt == PL_MAX ? HOLD : PULSE;
        n.cnt = c.cnt == PL_MAX ? '0 : c.cnt + 1'b1;
      end
      default: begin
        n.st = (!s && c.cnt == DB_MAX) ? IDLE : HOLD;
        n.cnt = (s || c.cnt == DB_MAX) ? '0 : c.cnt + 1'b1;
      end
    endcase
    return n;
  endfunction
  // two-flop synchronisers, bit 0 = set button, bit 1 = clear button
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_clr, btn_set};
      sync2 <= sync1;
    end
  end
  // next state of both channels; a clr pulse colliding with a set pulse is dropped straight to HOLD
  always_comb begin
    ns = step(cs, sync2[0]);
    nc_raw = step(cc, sync2[1]);
    cfl = nc_raw.st == PULSE && cc.st != PULSE && (cs.st == PULSE || ns.st == PULSE);
    nc = nc_raw;
    nc.st = cfl ? HOLD : nc_raw.st;
    nc.cnt = cfl ? '0 : nc_raw.cnt;
  end
  // channel state registers and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      cs.st <= IDLE;
      cs.cnt <= '0;
      cc.st <= IDLE;
      cc.cnt <= '0;
      pre <= 1'b0;
      clr <= 1'b0;
      conflict <= 1'b0;
      d <= 1'b0;
    end else begin
      cs <= ns;
      cc <= nc;
      pre <= ns.st == PULSE;
      clr <= nc.st == PULSE && ns.st != PULSE;
      conflict <= cfl;
      d <= d_in;
    end
  end
endmodule

// File: tb/tb_v_preclr_pulse_gen.sv
// tb_v_preclr_pulse_gen: directed scoreboard bench for the pre/clr pulse generator
module tb_v_preclr_pulse_gen;
  logic clk = 1'b0;
  logic rst, btn_set, btn_clr, d_in;
  logic pre, clr, d, conflict;
  logic rst2, btn_set2;
  logic pre2, clr2, d2, conflict2;
  logic [3:0] sbq[$];
  logic [3:0] got, want;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  v_preclr_pulse_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(5), .PULSE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_clr(btn_clr), .d_in(d_in),
    .pre(pre), .clr(clr), .d(d), .conflict(conflict)
  );

  v_preclr_pulse_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(5), .PULSE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst2), .btn_set(btn_set2), .btn_clr(1'b0), .d_in(d_in),
    .pre(pre2), .clr(clr2), .d(d2), .conflict(conflict2)
  );

  task automatic cyc(input logic r, input logic bs, input logic bc, input logic di,
                     input logic [3:0] e, input string tag);
    rst = r; btn_set = bs; btn_clr = bc; d_in = di; rst2 = r; btn_set2 = 1'b0;
    sbq.push_back(e);
    @(posedge clk); #1;
    got = {pre, clr, conflict, d};
    want = sbq.pop_front();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got{pre,clr,conflict,d}=%b exp=%b", tag, got, want);
    end
  endtask

  task automatic cyc2(input logic r, input logic bs, input logic p, input string tag);
    rst = 1'b0; btn_set = 1'b0; btn_clr = 1'b0; d_in = 1'b0; rst2 = r; btn_set2 = bs;
    sbq.push_back({p, 3'b000});
    @(posedge clk); #1;
    got = {pre2, clr2, conflict2, d2};
    want = sbq.pop_front();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got{pre,clr,conflict,d}=%b exp=%b", tag, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 4'b0000, "reset");
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, {(i == 5), 3'b000}, "set_hold");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 4'b0000, "short_release");
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 4'b0000, "no_repulse");
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 4'b0000, "release");
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, {(i == 5), 3'b000}, "repress");
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 4'b0000, "release2");
    for (int r = 0; r < 5; r++) begin
      cyc(0, 0, 1, 0, 4'b0000, "glitch");
      cyc(0, 0, 0, 0, 4'b0000, "glitch");
      cyc(0, 0, 0, 0, 4'b0000, "glitch");
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 4'b0000, "glitch_tail");
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, (i == 5) ? 4'b1010 : 4'b0000, "both");
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 4'b0000, "both_release");
    cyc(0, 0, 0, 1, 4'b0001, "dpipe");
    cyc(0, 0, 0, 0, 4'b0000, "dpipe");
    cyc(0, 0, 0, 1, 4'b0001, "dpipe");
    cyc(0, 0, 0, 1, 4'b0001, "dpipe");
    cyc(0, 0, 0, 0, 4'b0000, "dpipe");
    for (int i = 0; i < 7; i++) cyc2(0, 1, (i >= 5), "p3_pulse");
    cyc2(1, 1, 0, "p3_rst");
    for (int i = 0; i < 8; i++) cyc2(0, 0, 0, "p3_noresume");
    for (int i = 0; i < 10; i++) cyc2(0, 1, (i >= 5 && i <= 7), "p3_len");
    for (int i = 0; i < 2; i++) cyc2(0, 0, 0, "p3_release");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
